imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 107 ++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes
// them to instruction memory, holding the CPU until the load completes.
//   clk         rising-edge system clock
//   rst         asynchronous active-low reset
//   start       load request, honoured only in IDLE or DONE
//   word_count  words to load (clamped to the memory depth)
//   byte_valid  source byte valid
//   byte_data   source byte
//   byte_ready  a byte is accepted this cycle when byte_valid is also high
//   mem_we      one-cycle write strobe per word
//   mem_addr    registered word address, held outside writes
//   mem_wdata   registered word data, held outside writes
//   cpu_hold    keeps the core's fetch PC held while high
//   busy        a load is in progress
//   done        the most recent load completed
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [1:0]            state;
    logic [1:0]            byte_idx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           word;
    logic [31:0]           next_word;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   last_addr;

    // Word with the incoming byte merged in; lets byte 3 be written in the
    // same edge that completes the word.
    always_comb begin
        next_word = word;
        next_word[{byte_idx, 3'b000} +: 8] = byte_data;
    end

    assign last_addr  = count - 1'b1;
    assign byte_ready = state == RECV;
    assign busy       = state == RECV || state == WRITE;
    assign done       = state == DONE;
    assign cpu_hold   = state != DONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            byte_idx  <= '0;
            addr      <= '0;
            word      <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        count    <= (word_count > DEPTH) ? DEPTH : word_count;
                        addr     <= '0;
                        byte_idx <= '0;
                        state    <= (word_count == '0) ? DONE : RECV;
                    end
                end
                RECV: begin
                    if (byte_valid) begin
                        word     <= next_word;
                        byte_idx <= byte_idx + 2'd1;
                        // Registering the write here makes WRITE's outputs
                        // come straight from flops.
                        if (byte_idx == 2'd3) begin
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= next_word;
                        end
                    end
                end
                WRITE: begin
                    if ({1'b0, addr} == last_addr) begin
                        state <= DONE;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= RECV;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
